// File: rtl/osc_phase_accum_pkg.sv
// Shared synthesis package for the oscillator phase accumulator and the
// pitch stage: slot geometry, phase width, slot index and sequencer states.
package osc_phase_accum_pkg;

   localparam int VOICES      = 8;
   localparam int V_OSC       = 4;
   localparam int V_WIDTH     = 3;
   localparam int O_WIDTH     = 2;
   localparam int OE_WIDTH    = 1;
   localparam int E_WIDTH     = O_WIDTH + OE_WIDTH;
   localparam int PH_WIDTH    = 32;
   localparam int PITCH_WIDTH = 24;
   localparam int SLOTS       = VOICES * V_OSC;
   localparam int SLOT_WIDTH  = V_WIDTH + O_WIDTH;

   // Slot index as seen on the sweep: oscillator is the fast-moving field.
   typedef struct packed {
      logic [V_WIDTH-1:0] vx;
      logic [O_WIDTH-1:0] ox;
   } slot_t;

   typedef enum logic [1:0] {
      SEQ_IDLE,
      SEQ_SWEEP,
      SEQ_DRAIN
   } seq_state_t;

endpackage

// File: rtl/osc_phase_accum_slot_sequencer.sv
// Frame sequencer: walks every slot once per sample_start, then holds busy
// for the two-cycle accumulator drain. Flags sample_start arriving too early.
module slot_sequencer
   import osc_phase_accum_pkg::*;
(
   input  logic  clk,
   input  logic  rst_n,
   input  logic  sample_start,
   output slot_t slot,
   output logic  stage0_valid,
   output logic  busy,
   output logic  frame_overrun
);

   localparam logic [SLOT_WIDTH-1:0] LAST_SLOT = SLOT_WIDTH'(SLOTS - 1);

   seq_state_t            state;
   seq_state_t            state_nxt;
   logic [SLOT_WIDTH-1:0] cnt;
   logic                  drain_last;
   logic                  accept;

   // Next-state logic; a start on the final drain cycle chains straight into a new sweep.
   always_comb begin
      // NOTE: every output of this block gets a default first so no path can infer a latch.
      state_nxt = state;
      accept    = 1'b0;
      case (state)
         SEQ_IDLE: begin
            if (sample_start) begin
               accept    = 1'b1;
               state_nxt = SEQ_SWEEP;
            end
         end
         SEQ_SWEEP: begin
            if (cnt == LAST_SLOT) state_nxt = SEQ_DRAIN;
         end
         SEQ_DRAIN: begin
            if (drain_last) begin
               if (sample_start) begin
                  accept    = 1'b1;
                  state_nxt = SEQ_SWEEP;
               end else begin
                  state_nxt = SEQ_IDLE;
               end
            end
         end
         default: state_nxt = SEQ_IDLE;
      endcase
   end

   // State register, slot counter, drain counter and overrun pulse.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state         <= SEQ_IDLE;
         cnt           <= '0;
         drain_last    <= 1'b0;
         frame_overrun <= 1'b0;
      end else begin
         // NOTE: sequential state uses non-blocking assignments so all registers update together.
         state         <= state_nxt;
         cnt           <= (state == SEQ_SWEEP && cnt != LAST_SLOT) ? cnt + 1'b1 : '0;
         drain_last    <= (state == SEQ_DRAIN) ? ~drain_last : 1'b0;
         frame_overrun <= sample_start && busy && !accept;
      end
   end

   assign slot         = slot_t'(cnt);
   assign stage0_valid = (state == SEQ_SWEEP);
   assign busy         = (state != SEQ_IDLE);

endmodule

// File: rtl/osc_phase_accum.sv
// Time-multiplexed phase accumulator fed by the pitch stage. Two stages:
// stage 0 presents the slot and captures its increment, stage 1 adds it to
// the stored phase and streams the result. Optional hard sync of
// oscillators 1..V_OSC-1 to oscillator 0: define OSC_HARD_SYNC_EN.
module osc_phase_accum
   import osc_phase_accum_pkg::*;
(
   input  logic                        sCLK_XVXOSC,
   input  logic                        iRST_N,
   input  logic                        sample_start,
   input  logic                        key_on,
   input  logic [V_WIDTH-1:0]          key_voice,
   output logic [V_WIDTH+E_WIDTH-1:0]  xxxx,
   input  logic [PITCH_WIDTH-1:0]      osc_pitch_val,
   output logic [PH_WIDTH-1:0]         phase_out,
   output logic [SLOT_WIDTH-1:0]       phase_slot,
   output logic                        phase_valid,
   output logic                        busy,
   output logic                        frame_overrun
);

   slot_t                s0_slot;
   logic                 s0_valid;
   logic                 s0_osc0;
   slot_t                slot_r;
   logic                 s1_valid;
   logic [PH_WIDTH-1:0]  inc_r;
   logic [VOICES-1:0]    pend;
   logic                 vreset;
   logic [PH_WIDTH-1:0]  phase_mem [SLOTS];
   logic [PH_WIDTH-1:0]  sum_lo;
   logic                 sync_zero;
   logic [PH_WIDTH-1:0]  wr_val;

   slot_sequencer u_seq (
      .clk           (sCLK_XVXOSC),
      .rst_n         (iRST_N),
      .sample_start  (sample_start),
      .slot          (s0_slot),
      .stage0_valid  (s0_valid),
      .busy          (busy),
      .frame_overrun (frame_overrun)
   );

   assign xxxx    = {s0_slot, {OE_WIDTH{1'b0}}};
   assign s0_osc0 = s0_valid && (s0_slot.ox == '0);

   // Stage 0 capture: increment, slot and the voice reset flag sampled at oscillator 0.
   always_ff @(posedge sCLK_XVXOSC or negedge iRST_N) begin
      if (!iRST_N) begin
         inc_r    <= '0;
         slot_r   <= '0;
         s1_valid <= 1'b0;
         vreset   <= 1'b0;
      end else begin
         s1_valid <= s0_valid;
         if (s0_valid) begin
            inc_r  <= PH_WIDTH'(osc_pitch_val);
            slot_r <= s0_slot;
         end
         if (s0_osc0) vreset <= pend[s0_slot.vx];
      end
   end

   // Pending note-on resets; a new key_on wins over the consume in the same cycle.
   always_ff @(posedge sCLK_XVXOSC or negedge iRST_N) begin
      if (!iRST_N) begin
         pend <= '0;
      end else begin
         for (int v = 0; v < VOICES; v++) begin
            if (key_on && key_voice == V_WIDTH'(v))
               pend[v] <= 1'b1;
            else if (s0_osc0 && s0_slot.vx == V_WIDTH'(v))
               pend[v] <= 1'b0;
         end
      end
   end

`ifdef OSC_HARD_SYNC_EN
   logic [PH_WIDTH:0] sum;
   logic              wrap0;

   assign sum       = {1'b0, phase_mem[slot_r]} + {1'b0, inc_r};
   assign sum_lo    = sum[PH_WIDTH-1:0];
   assign sync_zero = wrap0 && (slot_r.ox != '0);

   // Oscillator 0 carry, held for its siblings until the next voice's oscillator 0.
   always_ff @(posedge sCLK_XVXOSC or negedge iRST_N) begin
      if (!iRST_N)
         wrap0 <= 1'b0;
      else if (s1_valid && slot_r.ox == '0)
         wrap0 <= sum[PH_WIDTH];
   end
`else
   assign sum_lo    = phase_mem[slot_r] + inc_r;
   assign sync_zero = 1'b0;
`endif

   assign wr_val = (vreset || sync_zero) ? '0 : sum_lo;

   // Stage 1 write-back of the updated phase to the store.
   always_ff @(posedge sCLK_XVXOSC or negedge iRST_N) begin
      if (!iRST_N) begin
         // NOTE: the store is a register array, not a RAM, so it can and must clear on reset.
         for (int i = 0; i < SLOTS; i++) phase_mem[i] <= '0;
      end else if (s1_valid) begin
         phase_mem[slot_r] <= wr_val;
      end
   end

   // Stage 1 output registers.
   always_ff @(posedge sCLK_XVXOSC or negedge iRST_N) begin
      if (!iRST_N) begin
         phase_out   <= '0;
         phase_slot  <= '0;
         phase_valid <= 1'b0;
      end else begin
         phase_valid <= s1_valid;
         if (s1_valid) begin
            phase_out  <= wr_val;
            phase_slot <= slot_r;
         end
      end
   end

endmodule

// File: tb/tb_osc_phase_accum.sv
// Self-checking bench for osc_phase_accum: randomized pitch tables and key
// events checked against a frame-level reference model of the phase store.
module tb_osc_phase_accum;
   import osc_phase_accum_pkg::*;

   logic                       clk = 1'b0;
   logic                       rst_n = 1'b0;
   logic                       sample_start = 1'b0;
   logic                       key_on = 1'b0;
   logic [V_WIDTH-1:0]         key_voice = '0;
   logic [V_WIDTH+E_WIDTH-1:0] xxxx;
   logic [PITCH_WIDTH-1:0]     osc_pitch_val;
   logic [PH_WIDTH-1:0]        phase_out;
   logic [SLOT_WIDTH-1:0]      phase_slot;
   logic                       phase_valid;
   logic                       busy;
   logic                       frame_overrun;

   logic [PITCH_WIDTH-1:0]     pitch_tab [SLOTS];
   longint unsigned            ref_ph    [SLOTS];
   bit                         pend_m    [VOICES];
   logic [PH_WIDTH-1:0]        exp_ph    [SLOTS];
   logic [PH_WIDTH-1:0]        got_ph    [SLOTS];
   int                         n_vec = 0;
   int                         n_err = 0;

   always #5 clk = ~clk;

   // Pitch stage stand-in: combinational lookup on the presented slot.
   assign osc_pitch_val = pitch_tab[xxxx[V_WIDTH+E_WIDTH-1:OE_WIDTH]];

   osc_phase_accum dut (
      .sCLK_XVXOSC   (clk),
      .iRST_N        (rst_n),
      .sample_start  (sample_start),
      .key_on        (key_on),
      .key_voice     (key_voice),
      .xxxx          (xxxx),
      .osc_pitch_val (osc_pitch_val),
      .phase_out     (phase_out),
      .phase_slot    (phase_slot),
      .phase_valid   (phase_valid),
      .busy          (busy),
      .frame_overrun (frame_overrun)
   );

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   task automatic model_clear();
      for (int s = 0; s < SLOTS; s++) ref_ph[s] = 0;
      for (int v = 0; v < VOICES; v++) pend_m[v] = 1'b0;
   endtask

   // Expected results of one frame. Voice v samples its pending reset when its
   // oscillator 0 is presented, which is frame offset 4*v+1; a key_on at or after
   // that point belongs to the next frame.
   task automatic compute_frame(input int kc, input int kv);
      bit              rst_v;
      bit              carry0;
      longint unsigned s;
      longint unsigned val;
      for (int v = 0; v < VOICES; v++) begin
         rst_v     = pend_m[v] || (kv == v && kc >= 1 && kc < V_OSC * v + 1);
         pend_m[v] = (kv == v && kc >= V_OSC * v + 1);
         carry0    = 1'b0;
         for (int o = 0; o < V_OSC; o++) begin
            s   = ref_ph[v * V_OSC + o] + longint'(pitch_tab[v * V_OSC + o]);
            val = s % (64'd1 << PH_WIDTH);
            if (o == 0) carry0 = (s >= (64'd1 << PH_WIDTH));
            if (rst_v) val = 0;
`ifdef OSC_HARD_SYNC_EN
            if (o != 0 && carry0) val = 0;
`endif
            ref_ph[v * V_OSC + o] = val;
            exp_ph[v * V_OSC + o] = PH_WIDTH'(val);
         end
      end
   endtask

   // One frame: sample_start at offset 0, optional key_on at offset kc, optional
   // extra sample_start at offset extra; every cycle's outputs are checked.
   task automatic run_frame(input int kc, input int kv, input int extra);
      logic [V_WIDTH+E_WIDTH-1:0] ex_x;
      logic                       ex_busy, ex_valid, ex_ovr;
      compute_frame(kc, kv);
      sample_start = 1'b1;
      for (int k = 1; k <= 36; k++) begin
         @(negedge clk);
         ex_busy  = (k <= SLOTS + 2);
         ex_valid = (k >= 3 && k <= SLOTS + 2);
         ex_ovr   = (extra > 0 && k == extra + 1);
         ex_x     = (k <= SLOTS) ? (V_WIDTH+E_WIDTH)'((k - 1) * 2) : '0;
         n_vec++;
         if (busy !== ex_busy) begin
            n_err++;
            $display("FAIL busy k=%0d got=%b exp=%b", k, busy, ex_busy);
         end
         n_vec++;
         if (phase_valid !== ex_valid) begin
            n_err++;
            $display("FAIL phase_valid k=%0d got=%b exp=%b", k, phase_valid, ex_valid);
         end
         n_vec++;
         if (frame_overrun !== ex_ovr) begin
            n_err++;
            $display("FAIL frame_overrun k=%0d got=%b exp=%b", k, frame_overrun, ex_ovr);
         end
         n_vec++;
         if (xxxx !== ex_x) begin
            n_err++;
            $display("FAIL xxxx k=%0d got=%h exp=%h", k, xxxx, ex_x);
         end
         if (ex_valid) begin
            got_ph[k - 3] = phase_out;
            n_vec++;
            if (phase_slot !== SLOT_WIDTH'(k - 3)) begin
               n_err++;
               $display("FAIL phase_slot k=%0d got=%0d exp=%0d", k, phase_slot, k - 3);
            end
            n_vec++;
            if (phase_out !== exp_ph[k - 3]) begin
               n_err++;
               $display("FAIL phase_out slot=%0d got=%h exp=%h", k - 3, phase_out, exp_ph[k - 3]);
            end
         end
         sample_start = (k == extra);
         key_on       = (k == kc);
         key_voice    = V_WIDTH'(kv);
      end
      sample_start = 1'b0;
      key_on       = 1'b0;
   endtask

   task automatic reset_dut();
      @(negedge clk);
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      model_clear();
      @(negedge clk);
   endtask

   task automatic key_between(input int v);
      key_on    = 1'b1;
      key_voice = V_WIDTH'(v);
      @(negedge clk);
      key_on    = 1'b0;
      pend_m[v] = 1'b1;
      @(negedge clk);
   endtask

   task automatic fill_tab(input logic [PITCH_WIDTH-1:0] val);
      for (int s = 0; s < SLOTS; s++) pitch_tab[s] = val;
   endtask

   task automatic fill_random();
      for (int s = 0; s < SLOTS; s++) pitch_tab[s] = PITCH_WIDTH'($urandom);
   endtask

   task automatic test_reset();
      fill_tab('0);
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      n_vec++;
      if ({xxxx, phase_out, phase_slot, phase_valid, busy, frame_overrun} !== '0) begin
         n_err++;
         $display("FAIL reset_outputs got=%h exp=0",
                  {xxxx, phase_out, phase_slot, phase_valid, busy, frame_overrun});
      end
      rst_n = 1'b1;
      model_clear();
      @(negedge clk);
      n_vec++;
      if ({phase_valid, busy, xxxx} !== '0) begin
         n_err++;
         $display("FAIL idle_after_reset got=%h exp=0", {phase_valid, busy, xxxx});
      end
   endtask

   task automatic test_basic();
      fill_tab(24'h000100);
      run_frame(-1, -1, 0);
      for (int s = 0; s < SLOTS; s++) begin
         n_vec++;
         if (got_ph[s] !== 32'h100) begin
            n_err++;
            $display("FAIL basic_frame1 slot=%0d got=%h exp=00000100", s, got_ph[s]);
         end
      end
      run_frame(-1, -1, 0);
      for (int s = 0; s < SLOTS; s++) begin
         n_vec++;
         if (got_ph[s] !== 32'h200) begin
            n_err++;
            $display("FAIL basic_frame2 slot=%0d got=%h exp=00000200", s, got_ph[s]);
         end
      end
   endtask

   task automatic test_key_between();
      fill_random();
      key_between(2);
      run_frame(-1, -1, 0);
      for (int s = 8; s < 12; s++) begin
         n_vec++;
         if (got_ph[s] !== '0) begin
            n_err++;
            $display("FAIL key_between_zero slot=%0d got=%h exp=0", s, got_ph[s]);
         end
      end
      run_frame(-1, -1, 0);
      for (int s = 8; s < 12; s++) begin
         n_vec++;
         if (got_ph[s] !== PH_WIDTH'(pitch_tab[s])) begin
            n_err++;
            $display("FAIL key_between_resume slot=%0d got=%h exp=%h", s, got_ph[s], pitch_tab[s]);
         end
      end
   endtask

   task automatic test_key_during();
      fill_tab(24'h000040);
      run_frame(13, 3, 0);
      n_vec++;
      if (got_ph[12] === '0) begin
         n_err++;
         $display("FAIL key_during_same_frame slot=12 got=%h exp=nonzero", got_ph[12]);
      end
      run_frame(-1, -1, 0);
      for (int s = 12; s < 16; s++) begin
         n_vec++;
         if (got_ph[s] !== '0) begin
            n_err++;
            $display("FAIL key_during_next_frame slot=%0d got=%h exp=0", s, got_ph[s]);
         end
      end
   endtask

   task automatic test_overrun();
      fill_random();
      run_frame(-1, -1, 10);
      run_frame(-1, -1, 0);
   endtask

   task automatic test_reset_mid();
      fill_random();
      sample_start = 1'b1;
      @(negedge clk);
      sample_start = 1'b0;
      repeat (10) @(negedge clk);
      rst_n = 1'b0;
      #1;
      n_vec++;
      if ({busy, phase_valid, xxxx, phase_out} !== '0) begin
         n_err++;
         $display("FAIL reset_mid_sweep got=%h exp=0", {busy, phase_valid, xxxx, phase_out});
      end
      @(negedge clk);
      rst_n = 1'b1;
      model_clear();
      @(negedge clk);
      run_frame(-1, -1, 0);
   endtask

   task automatic test_wrap_sync();
      logic [PH_WIDTH-1:0] ex_sib;
      reset_dut();
      fill_tab('0);
      pitch_tab[0] = 24'hFFFFFF;
      pitch_tab[5] = 24'hFFFFFF;
      for (int s = 1; s < 4; s++) pitch_tab[s] = 24'h10;
      pitch_tab[6] = 24'h10;
      for (int i = 0; i < 256; i++) run_frame(-1, -1, 0);
      pitch_tab[0] = 24'h80;
      pitch_tab[5] = 24'h80;
      run_frame(-1, -1, 0);
      pitch_tab[0] = 24'h100;
      pitch_tab[5] = 24'h100;
      run_frame(-1, -1, 0);
      n_vec++;
      if (got_ph[5] !== 32'h80) begin
         n_err++;
         $display("FAIL wrap_slot5 got=%h exp=00000080", got_ph[5]);
      end
      n_vec++;
      if (got_ph[0] !== 32'h80) begin
         n_err++;
         $display("FAIL wrap_slot0 got=%h exp=00000080", got_ph[0]);
      end
`ifdef OSC_HARD_SYNC_EN
      ex_sib = '0;
`else
      ex_sib = 32'h1020;
`endif
      for (int s = 1; s < 4; s++) begin
         n_vec++;
         if (got_ph[s] !== ex_sib) begin
            n_err++;
            $display("FAIL sync_sibling slot=%0d got=%h exp=%h", s, got_ph[s], ex_sib);
         end
      end
      n_vec++;
      if (got_ph[6] !== 32'h1020) begin
         n_err++;
         $display("FAIL sync_other_voice slot=6 got=%h exp=00001020", got_ph[6]);
      end
   endtask

   task automatic test_random();
      int kc, kv;
      for (int f = 0; f < 24; f++) begin
         fill_random();
         if ($urandom_range(0, 2) == 0) key_between(int'($urandom_range(0, VOICES - 1)));
         kc = ($urandom_range(0, 1) == 0) ? -1 : int'($urandom_range(1, SLOTS + 2));
         kv = int'($urandom_range(0, VOICES - 1));
         run_frame(kc, kv, 0);
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_key_between();
      test_key_during();
      test_overrun();
      test_reset_mid();
      test_random();
      test_wrap_sync();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/osc_phase_accum.md
# osc_phase_accum

Time-multiplexed phase accumulator that sits directly downstream of the pitch stage. Once per sample frame it sweeps every voice/oscillator slot, drives the slot index (`xxxx`) to the pitch stage and takes back the combinational `osc_pitch_val` as a phase increment. It adds the increment to that slot's stored phase and streams the updated phase to the waveform stage. It also applies note-on phase reset per voice and, optionally, hard sync of oscillators 1..V_OSC-1 to oscillator 0.

## Interface
- `VOICES`, 8, number of voices
- `V_OSC`, 4, oscillators per voice
- `V_WIDTH`, 3, voice index width
- `O_WIDTH`, 2, oscillator index width
- `OE_WIDTH`, 1, sub-oscillator (envelope) bit width; driven 0 by this block
- `E_WIDTH`, O_WIDTH+OE_WIDTH, slot element width
- `PH_WIDTH`, 32, phase accumulator width
- `sCLK_XVXOSC`  in  1  single clock; all state on rising edge
- `iRST_N`  in  1  asynchronous, active-low reset
- `sample_start`  in  1  one-cycle pulse; starts a frame sweep
- `key_on`  in  1  one-cycle pulse; requests phase reset of voice `key_voice`
- `key_voice`  in  V_WIDTH  voice index for `key_on`
- `xxxx`  out  V_WIDTH+E_WIDTH  slot index to pitch stage: {vx, ox, OE=0}
- `osc_pitch_val`  in  24  phase increment for the slot currently on `xxxx`; same-cycle combinational return
- `phase_out`  out  PH_WIDTH  updated phase of `phase_slot`
- `phase_slot`  out  V_WIDTH+O_WIDTH  {vx, ox} of `phase_out`
- `phase_valid`  out  1  `phase_out` and `phase_slot` valid this cycle
- `busy`  out  1  sweep in progress, including the pipeline drain
- `frame_overrun`  out  1  one-cycle pulse: `sample_start` arrived while busy

## Operation
- Phase store: register array of VOICES*V_OSC entries × PH_WIDTH. Async reset clears every entry to 0.
- Sweep order: slot = {vx, ox}, with ox fastest, 0..VOICES*V_OSC-1. Oscillator 0 of each voice is always processed before its siblings.
- Stage 0, cycle c: `xxxx` = {slot, 0}. At the clock edge, register `osc_pitch_val` (zero-extended to PH_WIDTH) as `inc_r`, the slot as `slot_r`, and the per-voice flags.
- Stage 1, cycle c+1:
  - `sum = phase[slot_r] + inc_r`, computed PH_WIDTH+1 wide; the carry is the wrap flag. The phase wraps modulo 2^PH_WIDTH.
  - Written value: 0 if the voice reset flag is set; 0 if the sync condition holds; otherwise `sum[PH_WIDTH-1:0]`.
  - At the clock edge, write the value to the store and to `phase_out`, and set `phase_valid`.
- Key reset:
  - `key_on` sets `pend[key_voice]`.
  - When slot ox==0 of voice v is in stage 0, `pend[v]` is copied into `vreset` and cleared.
  - If `key_on` for the same v arrives in that cycle, the set wins: `pend[v]` stays 1 and is applied next frame, while this frame still uses the old value.
- Idle: `xxxx` holds slot 0 and `phase_valid`=0.

## Timing
- Reset values:
  - `xxxx`=0, `phase_out`=0, `phase_slot`=0.
  - `phase_valid`, `busy` and `frame_overrun` = 0.
  - All `pend` bits, `vreset` and `wrap0` = 0.
- Latency: slot on `xxxx` in cycle c → `phase_valid` high in cycle c+2 with that slot's result.
- A frame starts the cycle after `sample_start` (slot 0 in stage 0).
- Frame length: VOICES*V_OSC stage-0 cycles (32 at the defaults), plus 2 cycles of drain.
- `busy` rises the cycle after `sample_start` and falls after the last `phase_valid`.
- `phase_valid` is continuous for VOICES*V_OSC cycles per frame.
- `sample_start` while busy is ignored; `frame_overrun` pulses the next cycle.
- `sample_start` on the cycle `busy` falls is accepted.
- Reset mid-sweep aborts immediately: the store clears and the next `sample_start` begins from slot 0.
- Slots are distinct and processed back-to-back, so there is no read-after-write hazard.

## Configuration
- Macro `OSC_HARD_SYNC_EN`.
- Defined:
  - Oscillator 0's stage-1 carry is latched into `wrap0` for its voice.
  - For ox = 1..V_OSC-1 of the same voice in the same frame, a set `wrap0` forces the written phase to 0.
  - `wrap0` is cleared when the next voice's oscillator 0 enters stage 1.
- Not defined: no `wrap0` logic; every oscillator accumulates independently.

## Structure
- Shared synth package holds:
  - `VOICES`, `V_OSC`, `V_WIDTH`, `O_WIDTH`, `OE_WIDTH`, `E_WIDTH` (shared with the pitch stage)
  - `PH_WIDTH`
  - a slot-index typedef `{vx, ox}`
- One sub-module, `slot_sequencer`: frame FSM (IDLE→SWEEP→DRAIN→IDLE), slot counter, `busy` and overrun generation.
- Accumulator datapath and `pend`/`wrap0` logic stay in the top module.

## Test plan
- Reset, then `sample_start` with `osc_pitch_val` fixed at 24'h000100 → 32 `phase_valid` cycles, slots 0..31 in order, each `phase_out`=0x100. Second frame → each 0x200.
- Preload slot 5 with 0xFFFFFF80 (run frames), increment 0x100 → `phase_out` = 0x00000080 (wrap).
- `key_on`, `key_voice`=2, between frames → voice 2 slots (8..11) output 0, other slots accumulate. The following frame resumes from the increment.
- `key_on` for voice 3 in the cycle slot 12 is in stage 0 → this frame's voice 3 accumulates normally; next frame's voice 3 outputs 0.
- `sample_start` at cycle 10 of a sweep → `frame_overrun` pulses once, sweep length unchanged, no restart.
- With `OSC_HARD_SYNC_EN` defined, voice 0 osc0 wraps this frame → slots 1..3 output 0 and voice 1 is unaffected. Without the macro → slots 1..3 accumulate.
